// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready CPU handshake with a fixed number of wait states.
// Optional byte-strobe writes are enabled by defining MEM_BYTE_STROBE_EN.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    // Handshake: req is sampled only in IDLE; a sampled req is the acceptance.
    // ready is a single-cycle pulse that completes the access; rdata and err
    // are meaningful only while ready is high. req outside IDLE is dropped.

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        capture;
    logic        enter_resp;

    logic [31:0] mem_q [DEPTH_WORDS];

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the access uses the live inputs while IDLE and the captured copy otherwise.
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          mem_we;

    always_comb begin
        acc_we    = (state_q == S_IDLE) ? we    : we_q;
        acc_addr  = (state_q == S_IDLE) ? addr  : addr_q;
        acc_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
        acc_be    = (state_q == S_IDLE) ? be    : be_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:AW+2]);
        acc_idx   = acc_addr[AW+1:2];
        mem_we    = enter_resp && acc_we && !acc_err;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (enter_resp) begin
                err_q <= acc_err;
                if (!acc_we) begin
                    rdata_q <= acc_err ? 32'd0 : mem_q[acc_idx];
                end
            end
        end
    end

    // Array is never cleared; reset only blocks a write on the reset edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
        end else if (mem_we) begin
`ifdef MEM_BYTE_STROBE_EN
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
`else
            mem_q[acc_idx] <= acc_wdata;
`endif
        end
    end

`ifndef MEM_BYTE_STROBE_EN
    logic unused_be;
    assign unused_be = ^acc_be;
`endif

    assign ready       = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign err         = ready && err_q;
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        req, req0;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, busy, err;
  logic [31:0] rdata;
  logic [1:0]  dbg;
  logic        ready0, busy0, err0;
  logic [31:0] rdata0;
  logic [1:0]  dbg0;

  int checks = 0;
  int errors = 0;

  bit          cur_sel;
  logic        c_ready, c_busy, c_err;
  logic [31:0] c_rdata;

`ifdef MEM_BYTE_STROBE_EN
  localparam logic [31:0] EXP_STROBE      = 32'h00BB00DD;
  localparam logic [31:0] EXP_STROBE_ZERO = 32'h00BB00DD;
`else
  localparam logic [31:0] EXP_STROBE      = 32'hAABBCCDD;
  localparam logic [31:0] EXP_STROBE_ZERO = 32'hFFFFFFFF;
`endif

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .rdata(rdata), .busy(busy), .err(err), .dbg_state_o(dbg)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready0), .rdata(rdata0), .busy(busy0), .err(err0), .dbg_state_o(dbg0)
  );

  assign c_ready = cur_sel ? ready0 : ready;
  assign c_busy  = cur_sel ? busy0  : busy;
  assign c_err   = cur_sel ? err0   : err;
  assign c_rdata = cur_sel ? rdata0 : rdata;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver: one access, reports latency (negedges after acceptance) and pulse shape
  task automatic drive_access(input bit sel, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              output logic [31:0] r, output logic e, output int lat,
                              output logic pulse_ok);
    cur_sel = sel;
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    if (sel) req0 = 1'b1; else req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; req0 = 1'b0;
    we = ~w; addr = 32'hFFFF_FFFE; wdata = ~d; be = ~b;
    lat = -1; r = '0; e = 1'b0; pulse_ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (c_ready === 1'b1) begin
        lat = k; r = c_rdata; e = c_err;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      pulse_ok = (c_ready === 1'b0) && (c_busy === 1'b0);
    end
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b0 || ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b/%b exp 0/0", ready, ready0); end
    checks++; if (busy !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b/%b exp 0/0", busy, busy0); end
    checks++; if (err !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL rst_err got %b/%b exp 0/0", err, err0); end
    checks++; if (rdata !== 32'd0 || rdata0 !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0", rdata, rdata0); end
    checks++; if (dbg !== 2'd0 || dbg0 !== 2'd0) begin errors++; $display("FAIL rst_state got %0d/%0d exp 0", dbg, dbg0); end
  endtask

  task automatic test_write_read();
    logic [31:0] r; logic e, p; int lat;
    drive_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", e); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL wr_rdata_hold got %h exp 0", r); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL wr_pulse got %b exp 1", p); end
    drive_access(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", lat); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", e); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL rd_pulse got %b exp 1", p); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] r; logic e, p; int lat; int busy_cnt; int rdy_at;
    drive_access(1'b1, 1'b1, 32'h04, 32'h12345678, 4'hF, r, e, lat, p);
    checks++; if (lat !== 0) begin errors++; $display("FAIL zw_wr_latency got %0d exp 0", lat); end
    cur_sel = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 32'h04; req0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    busy_cnt = 0; rdy_at = -1;
    for (int k = 0; k < 5; k++) begin
      if (busy0 === 1'b1) busy_cnt++;
      if (ready0 === 1'b1 && rdy_at < 0) begin
        rdy_at = k;
        checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL zw_rdata got %h exp 12345678", rdata0); end
      end
      @(negedge clk);
    end
    checks++; if (rdy_at !== 0) begin errors++; $display("FAIL zw_rd_latency got %0d exp 0", rdy_at); end
    checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL zw_busy_cycles got %0d exp 1", busy_cnt); end
  endtask

  task automatic test_error();
    logic [31:0] r; logic e, p; int lat;
    drive_access(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, r, e, lat, p);
    checks++; if (e !== 1'b1 || lat !== 2) begin errors++; $display("FAIL err_wr_misalign got err=%b lat=%0d exp err=1 lat=2", e, lat); end
    drive_access(1'b0, 1'b1, 32'h410, 32'hFFFFFFFF, 4'hF, r, e, lat, p);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_range got %b exp 1", e); end
    drive_access(1'b0, 1'b0, 32'h13, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (e !== 1'b1 || r !== 32'd0 || lat !== 2) begin errors++; $display("FAIL err_rd_misalign got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=2", e, r, lat); end
    drive_access(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL err_array_kept got %h err=%b exp deadbeef err=0", r, e); end
    drive_access(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL err_rd_range got err=%b rdata=%h exp err=1 rdata=0", e, r); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", p); end
  endtask

  task automatic test_back_to_back();
    int pulses; logic exp_rdy, exp_busy;
    cur_sel = 1'b0;
    pulses = 0;
    @(negedge clk);
    we = 1'b0; addr = 32'h10; req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_rdy  = (k == 2) || (k == 6) || (k == 10);
      exp_busy = (k <= 10) && ((k % 4) != 3);
      if (ready === 1'b1) pulses++;
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, ready, exp_rdy); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy, exp_busy); end
      if (exp_rdy) begin
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata k=%0d got %h exp deadbeef", k, rdata); end
      end
      if (k == 9) req = 1'b0;
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] r; logic e, p; int lat;
    drive_access(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, r, e, lat, p);
    cur_sel = 1'b0;
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h22222222; be = 4'hF; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rf_busy_before got %b exp 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || dbg !== 2'd0) begin errors++; $display("FAIL rf_async got busy=%b ready=%b state=%0d exp 0/0/0", busy, ready, dbg); end
    @(negedge clk);
    reset_n = 1'b1;
    drive_access(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL rf_discarded got %h exp 11111111", r); end
    // reset landing in RESP
    @(negedge clk);
    we = 1'b0; addr = 32'h20; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1 || rdata !== 32'h11111111) begin errors++; $display("FAIL rf_resp got ready=%b rdata=%h exp 1/11111111", ready, rdata); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL rf_resp_reset got ready=%b rdata=%h err=%b exp 0/0/0", ready, rdata, err); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_byte_strobe();
    logic [31:0] r; logic e, p; int lat;
    drive_access(1'b0, 1'b1, 32'h30, 32'h00000000, 4'hF, r, e, lat, p);
    drive_access(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, r, e, lat, p);
    drive_access(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (r !== EXP_STROBE) begin errors++; $display("FAIL strobe_0101 got %h exp %h", r, EXP_STROBE); end
    drive_access(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, r, e, lat, p);
    checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL strobe_zero_done got lat=%0d err=%b exp 2/0", lat, e); end
    drive_access(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, r, e, lat, p);
    checks++; if (r !== EXP_STROBE_ZERO) begin errors++; $display("FAIL strobe_0000 got %h exp %h", r, EXP_STROBE_ZERO); end
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = 4'hF; cur_sel = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_write_read();
    test_zero_wait();
    test_error();
    test_back_to_back();
    test_reset_inflight();
    test_byte_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
